// File: rtl/operand_fetch_stage_if.sv
// Bundle of the decode->operand-fetch->execute signals for operand_fetch_stage.
// master = decode/control/writeback side, slave = the operand fetch stage.
interface operand_fetch_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] imm;
  logic              imm_sel;
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic              in_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  logic              sel;
  logic              out_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, imm, imm_sel,
           in_valid, stall, flush,
    input  in_ready, op_a, data_1, data_2, sel, out_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_1, rd_addr_2, imm, imm_sel,
           in_valid, stall, flush,
    output in_ready, op_a, data_1, data_2, sel, out_valid
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 2R/1W register file with write-through bypass plus the
// execute pipeline register. Optional macro OPERAND_FETCH_REG0_ZERO_EN makes reg 0 read as zero.
module operand_fetch_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_fetch_stage_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_fire;
  logic [DATA_W-1:0] read_1;
  logic [DATA_W-1:0] read_2;

  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] data_1_q;
  logic [DATA_W-1:0] data_2_q;
  logic              sel_q;
  logic              out_valid_q;

`ifdef OPERAND_FETCH_REG0_ZERO_EN
  // Reg 0 is never written, so it keeps its reset value of zero; this also
  // disables the bypass for address 0.
  assign wr_fire = bus.wr_en && (bus.wr_addr != '0);
`else
  assign wr_fire = bus.wr_en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Write-then-read: a same-cycle writeback to the read address is forwarded.
  always_comb begin
    read_1 = regs[bus.rd_addr_1];
    read_2 = regs[bus.rd_addr_2];
    if (wr_fire && (bus.wr_addr == bus.rd_addr_1)) read_1 = bus.wr_data;
    if (wr_fire && (bus.wr_addr == bus.rd_addr_2)) read_2 = bus.wr_data;
  end

  // Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
  // in_ready = ~stall. Flush overrides everything and empties the stage.
  assign bus.in_ready = ~bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      data_1_q    <= '0;
      data_2_q    <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      op_a_q      <= '0;
      data_1_q    <= '0;
      data_2_q    <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        op_a_q      <= read_1;
        data_1_q    <= read_2;
        data_2_q    <= bus.imm;
        sel_q       <= bus.imm_sel;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.op_a      = op_a_q;
  assign bus.data_1    = data_1_q;
  assign bus.data_2    = data_2_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed plus randomized bench for operand_fetch_stage against a behavioural
// register-file / pipeline model.
module tb_operand_fetch_stage;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
`ifdef OPERAND_FETCH_REG0_ZERO_EN
  localparam bit REG0_ZERO = 1'b1;
`else
  localparam bit REG0_ZERO = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  operand_fetch_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  operand_fetch_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DATA_W-1:0] m_regs [2**ADDR_W];
  logic [DATA_W-1:0] e_op_a, e_data_1, e_data_2;
  logic              e_sel, e_valid;

  task automatic model_reset();
    for (int i = 0; i < 2**ADDR_W; i++) m_regs[i] = '0;
    e_op_a = '0; e_data_1 = '0; e_data_2 = '0; e_sel = 1'b0; e_valid = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (REG0_ZERO && a == 0) return '0;
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return m_regs[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("op_a",      32'(bus.op_a),      32'(e_op_a));
    chk("data_1",    32'(bus.data_1),    32'(e_data_1));
    chk("data_2",    32'(bus.data_2),    32'(e_data_2));
    chk("sel",       32'(bus.sel),       32'(e_sel));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
  endtask

  // driver tasks
  task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2,
                       input logic [DATA_W-1:0] im, input logic isel,
                       input logic iv, input logic st, input logic fl);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_addr_1 = ra1; bus.rd_addr_2 = ra2;
    bus.imm = im; bus.imm_sel = isel;
    bus.in_valid = iv; bus.stall = st; bus.flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: predict the stage from the current inputs, clock, compare.
  task automatic tick();
    logic [DATA_W-1:0] r1, r2;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!bus.stall));
    r1 = model_read(bus.rd_addr_1);
    r2 = model_read(bus.rd_addr_2);
    if (bus.flush) begin
      e_op_a = '0; e_data_1 = '0; e_data_2 = '0; e_sel = 1'b0; e_valid = 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        e_op_a = r1; e_data_1 = r2; e_data_2 = bus.imm; e_sel = bus.imm_sel; e_valid = 1'b1;
      end else begin
        e_valid = 1'b0;
      end
    end
    if (bus.wr_en && !(REG0_ZERO && bus.wr_addr == 0)) m_regs[bus.wr_addr] = bus.wr_data;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // write reg2, then read it on port 1
    drive(1'b1, 3'd2, 8'h11, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("op_a_reg2", 32'(bus.op_a), 32'h11);
    chk("valid_after_read", 32'(bus.out_valid), 32'd1);

    // same-cycle bypass on port 2
    drive(1'b1, 3'd4, 8'hC3, 3'd2, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("data_1_bypass", 32'(bus.data_1), 32'hC3);

    // immediate path, then register path
    drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd2, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk("data_2_imm", 32'(bus.data_2), 32'h7F);
    chk("sel_imm", 32'(bus.sel), 32'd1);
    drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd2, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("sel_reg", 32'(bus.sel), 32'd0);

    // stall holds for 3 cycles while a writeback lands
    drive(1'b1, 3'd5, 8'h22, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd4, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk("op_a_pre_stall", 32'(bus.op_a), 32'h22);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd6, 8'h66, 3'd2, 3'd6, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("stall_op_a", 32'(bus.op_a), 32'h22);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd6, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("wr_during_stall", 32'(bus.op_a), 32'h66);

    // flush beats stall and in_valid
    drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd5, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_op_a", 32'(bus.op_a), 32'd0);
    chk("flush_data_2", 32'(bus.data_2), 32'd0);

    // register 0 write with same-cycle read, then a plain read
    drive(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("reg0_bypass", 32'(bus.op_a), REG0_ZERO ? 32'h00 : 32'hFF);
    drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("reg0_read", 32'(bus.op_a), REG0_ZERO ? 32'h00 : 32'hFF);

    // asynchronous reset mid-cycle after writing reg3
    drive(1'b1, 3'd3, 8'h5A, 3'd3, 3'd2, 8'h9A, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk("pre_reset_op_a", 32'(bus.op_a), 32'h5A);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("reg3_cleared", 32'(bus.op_a), 32'h00);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
            ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute operand stage of the 4-stage pipeline: register file plus the pipeline register that feeds the downstream 8-bit 2:1 operand mux.
- Holds 2**ADDR_W general registers with two read ports and one write port from writeback.
- Latches operand A, register operand B (data_1), immediate (data_2) and the mux select (sel) for the execute stage.
- Supports stall and flush.

Parameters:
DATA_W, 8, operand/register width
ADDR_W, 3, register address width; register count = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  writeback write enable
wr_addr  input  ADDR_W  writeback destination register
wr_data  input  DATA_W  writeback data
rd_addr_1  input  ADDR_W  source register for op_a
rd_addr_2  input  ADDR_W  source register for data_1
imm  input  DATA_W  decoded immediate
imm_sel  input  1  1 = execute uses immediate (data_2); 0 = register (data_1)
in_valid  input  1  decode presents a valid instruction
stall  input  1  hazard stall from control; hold stage contents
flush  input  1  branch flush; kill stage contents
in_ready  output  1  stage can accept a new instruction
op_a  output  DATA_W  latched operand A
data_1  output  DATA_W  latched register operand B, to mux data_1
data_2  output  DATA_W  latched immediate, to mux data_2
sel  output  1  latched imm_sel, to mux sel
out_valid  output  1  outputs hold a valid instruction

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed): all registers = 0; op_a, data_1, data_2 = 0; sel = 0; out_valid = 0. Writes are ignored while reset is asserted.
- Register file write:
  - On a rising edge with wr_en = 1, reg[wr_addr] <= wr_data.
  - The write happens regardless of stall/flush.
- Register file read:
  - Combinational read of reg[rd_addr_n].
  - Same-cycle bypass: if wr_en = 1 and wr_addr == rd_addr_n, the read value is wr_data (write-then-read semantics).
  - Each port bypasses independently; both ports may read the same address.
- in_ready = ~stall (combinational).
- Pipeline register update on each rising edge, priority order:
  1. flush = 1: out_valid <= 0; op_a, data_1, data_2, sel <= 0. Flush wins over stall and in_valid.
  2. stall = 1: all outputs hold their values, including out_valid. The incoming instruction is not consumed.
  3. in_valid = 1: op_a <= read1 (bypassed); data_1 <= read2 (bypassed); data_2 <= imm; sel <= imm_sel; out_valid <= 1.
  4. in_valid = 0: out_valid <= 0; data outputs hold.
- Latency: 1 cycle from accepted in_valid to out_valid.
- A stalled stage does not re-read the register file. Operands latched before a stall stay stale; the hazard unit is responsible for ordering.
- Address range: every ADDR_W value is a legal address, so there is no wrap or out-of-range case.
- Reset mid-operation: outputs go to reset values immediately. The register file contents are cleared.

Optional Feature:
- Macro: OPERAND_FETCH_REG0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0: writes to address 0 are discarded, and reads of address 0 return 0.
  - The bypass path is also suppressed for address 0.
- Undefined: register 0 is an ordinary register, like all others.

Test Plan:
- Reset: drive rst_n low mid-clock after writing reg[3] = 0x5A. Outputs go to 0 and out_valid = 0 without waiting for an edge. After release, reading reg 3 returns 0x00.
- Write/read plus bypass:
  - Write reg[2] = 0x11, then next cycle present rd_addr_1 = 2, in_valid = 1. op_a = 0x11 one cycle later, out_valid = 1.
  - Same cycle: wr_en with reg[4] = 0xC3 and rd_addr_2 = 4. data_1 = 0xC3 at the next edge.
- Immediate path: in_valid = 1, imm = 0x7F, imm_sel = 1. Next cycle data_2 = 0x7F, sel = 1. A following instruction with imm_sel = 0 gives sel = 0.
- Stall:
  - Latch an instruction with op_a = 0x22, then assert stall for 3 cycles while presenting different operands.
  - Outputs stay 0x22/valid, and in_ready = 0 for those 3 cycles.
  - A writeback during the stall still updates the register file.
- Flush priority: assert flush and stall together with in_valid = 1. Next edge: out_valid = 0 and all data outputs = 0.
- Macro on: write reg[0] = 0xFF with rd_addr_1 = 0 in the same cycle. op_a = 0x00 then and on later reads. Macro off: op_a = 0xFF.
